// File: rtl/nv_ram_fifo_ctrl_19x32.sv
// -----------------------------------------------------------------------------
// nv_ram_fifo_ctrl_19x32
//
// Controller for a 32-bit FIFO whose storage is an external 19-entry RAM with
// a registered read path, followed by a 4-entry output buffer that gives the
// consumer a zero-latency pop interface.
//
// Read pipeline:
//   cycle t   : issue   (ram_re=1, ram_ra=rd_ptr, RAM captures the address)
//   cycle t+1 : v1=1    (ram_ore=1, RAM output register loads the word)
//   cycle t+2 : v2=1    (ram_dout captured into the output buffer)
// A read is only issued when the output buffer has room for every word that
// is already in the pipeline, so the buffer can never overflow.
//
// Ports:
//   clk, rst              sole clock; asynchronous active-high reset
//   clr                   synchronous flush of all contents and in-flight reads
//   in_valid/in_ready/in_data     push handshake
//   out_valid/out_ready/out_data  pop handshake
//   fifo_count            words held (RAM + read pipeline + output buffer)
//   ram_wa/ram_we/ram_di  RAM write port
//   ram_ra/ram_re         RAM read-address capture
//   ram_ore               RAM output-register enable
//   ram_dout              RAM registered read data
//   ram_byp_sel/ram_dbyp  RAM bypass path, unused (tied off)
//   pwrbus_ram_pd -> ram_pwrbus_ram_pd  power control pass-through
// -----------------------------------------------------------------------------
module nv_ram_fifo_ctrl_19x32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  fifo_count,
    output logic [4:0]  ram_wa,
    output logic        ram_we,
    output logic [31:0] ram_di,
    output logic [4:0]  ram_ra,
    output logic        ram_re,
    output logic        ram_ore,
    output logic        ram_byp_sel,
    output logic [31:0] ram_dbyp,
    input  logic [31:0] ram_dout,
    input  logic [31:0] pwrbus_ram_pd,
    output logic [31:0] ram_pwrbus_ram_pd
);

    localparam logic [4:0] RAM_LAST  = 5'd18;  // highest RAM address
    localparam logic [4:0] RAM_DEPTH = 5'd19;
    localparam logic [3:0] OB_DEPTH  = 4'd4;

    function automatic logic [4:0] ram_ptr_inc(input logic [4:0] ptr);
        return (ptr == RAM_LAST) ? 5'd0 : ptr + 5'd1;
    endfunction

    // State
    logic [4:0] wr_ptr_q, wr_ptr_d;
    logic [4:0] rd_ptr_q, rd_ptr_d;
    logic [4:0] ram_cnt_q, ram_cnt_d;
    logic       v1_q, v1_d;
    logic       v2_q, v2_d;
    logic [2:0] ob_cnt_q, ob_cnt_d;
    logic [1:0] ob_wp_q, ob_wp_d;
    logic [1:0] ob_rp_q, ob_rp_d;
    logic [31:0] ob_mem [4];

    // Per-cycle events
    logic       push;
    logic       issue;
    logic       capture;
    logic       pop;
    logic [3:0] ob_reserved;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        v1_d      = 1'b0;
        v2_d      = 1'b0;
        ob_cnt_d  = ob_cnt_q;
        ob_wp_d   = ob_wp_q;
        ob_rp_d   = ob_rp_q;

        // in_ready is forced low while reset is held; it depends only on the
        // registered count, so a pop cannot open a slot in the same cycle.
        in_ready = !rst && !clr && (ram_cnt_q < RAM_DEPTH);
        push     = in_valid && in_ready;

        // Output-buffer credit: buffered words plus words still in the pipe.
        ob_reserved = {1'b0, ob_cnt_q} + {3'b000, v1_q} + {3'b000, v2_q};
        issue       = !clr && (ram_cnt_q != 5'd0) && (ob_reserved < OB_DEPTH);

        out_valid = (ob_cnt_q != 3'd0);
        capture   = v2_q && !clr;
        pop       = out_valid && out_ready && !clr;

        if (clr) begin
            // Flush: everything zeroed, in-flight read data dropped.
            wr_ptr_d  = 5'd0;
            rd_ptr_d  = 5'd0;
            ram_cnt_d = 5'd0;
            ob_cnt_d  = 3'd0;
            ob_wp_d   = 2'd0;
            ob_rp_d   = 2'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ram_ptr_inc(wr_ptr_q);
            end
            if (issue) begin
                rd_ptr_d = ram_ptr_inc(rd_ptr_q);
            end
            unique case ({push, issue})
                2'b10:   ram_cnt_d = ram_cnt_q + 5'd1;
                2'b01:   ram_cnt_d = ram_cnt_q - 5'd1;
                default: ram_cnt_d = ram_cnt_q;
            endcase

            v1_d = issue;
            v2_d = v1_q;

            // The 4-entry buffer pointers wrap naturally at 2 bits.
            if (capture) begin
                ob_wp_d = ob_wp_q + 2'd1;
            end
            if (pop) begin
                ob_rp_d = ob_rp_q + 2'd1;
            end
            unique case ({capture, pop})
                2'b10:   ob_cnt_d = ob_cnt_q + 3'd1;
                2'b01:   ob_cnt_d = ob_cnt_q - 3'd1;
                default: ob_cnt_d = ob_cnt_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= 5'd0;
            rd_ptr_q  <= 5'd0;
            ram_cnt_q <= 5'd0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            ob_cnt_q  <= 3'd0;
            ob_wp_q   <= 2'd0;
            ob_rp_q   <= 2'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            ob_cnt_q  <= ob_cnt_d;
            ob_wp_q   <= ob_wp_d;
            ob_rp_q   <= ob_rp_d;
        end
    end

    // NOTE: buffer storage carries no reset; ob_cnt_q alone decides which
    // entries are meaningful, and out_data is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (capture) begin
            ob_mem[ob_wp_q] <= ram_dout;
        end
    end

    // RAM write port: combinational in the push cycle.
    assign ram_we = push;
    assign ram_wa = wr_ptr_q;
    assign ram_di = in_data;

    // RAM read port.
    assign ram_re  = issue;
    assign ram_ra  = rd_ptr_q;
    assign ram_ore = v1_q;  // low keeps the RAM output register holding

    assign out_data   = out_valid ? ob_mem[ob_rp_q] : 32'd0;
    assign fifo_count = {1'b0, ram_cnt_q} + {5'd0, v1_q} + {5'd0, v2_q} + {3'd0, ob_cnt_q};

    assign ram_byp_sel       = 1'b0;
    assign ram_dbyp          = 32'd0;
    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

    // The issue credit must keep the output buffer from ever overflowing.
    a_ob_no_overflow : assert property (
        @(posedge clk) disable iff (rst) !(capture && !pop && (ob_cnt_q == 3'd4))
    );

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_19x32.sv
// -----------------------------------------------------------------------------
// tb_nv_ram_fifo_ctrl_19x32
//
// Bench for nv_ram_fifo_ctrl_19x32. Contains a behavioural model of the
// external RAM (write port, address register, output register) and a
// scoreboard: every accepted push appends its word to a queue of expected
// data; a monitor on the falling edge pops and compares whenever a pop
// handshake occurs. The queue length is the number of words the FIFO must
// report in fifo_count. Expected RAM addresses are derived from push/read
// counts modulo the RAM depth.
// -----------------------------------------------------------------------------
module tb_nv_ram_fifo_ctrl_19x32;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  fifo_count;
    logic [4:0]  ram_wa;
    logic        ram_we;
    logic [31:0] ram_di;
    logic [4:0]  ram_ra;
    logic        ram_re;
    logic        ram_ore;
    logic        ram_byp_sel;
    logic [31:0] ram_dbyp;
    logic [31:0] ram_dout;
    logic [31:0] pwrbus_ram_pd;
    logic [31:0] ram_pwrbus_ram_pd;

    always #5 clk = ~clk;

    nv_ram_fifo_ctrl_19x32 dut (
        .clk               (clk),
        .rst               (rst),
        .clr               (clr),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .fifo_count        (fifo_count),
        .ram_wa            (ram_wa),
        .ram_we            (ram_we),
        .ram_di            (ram_di),
        .ram_ra            (ram_ra),
        .ram_re            (ram_re),
        .ram_ore           (ram_ore),
        .ram_byp_sel       (ram_byp_sel),
        .ram_dbyp          (ram_dbyp),
        .ram_dout          (ram_dout),
        .pwrbus_ram_pd     (pwrbus_ram_pd),
        .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd)
    );

    // ---------------- external RAM model ----------------
    logic [31:0] ram_mem [19];
    logic [4:0]  ram_ra_reg;

    always @(posedge clk) begin
        if (ram_we && ram_wa < 5'd19) ram_mem[ram_wa] <= ram_di;
        if (ram_re) ram_ra_reg <= ram_ra;
        if (ram_ore) ram_dout <= ram_mem[ram_ra_reg];
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q [$];
    logic [4:0]  exp_wa;
    logic [4:0]  exp_ra;
    int          ram_pending;  // words written but not yet read from RAM
    int          errors = 0;
    int          checks = 0;
    int          pop_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] addr_inc(input logic [4:0] a);
        return (a == 5'd18) ? 5'd0 : a + 5'd1;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_wa      = 5'd0;
            exp_ra      = 5'd0;
            ram_pending = 0;
        end else begin
            check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
            if (exp_q.size() == 23) check("in_ready_when_full", 32'(in_ready), 32'd0);
            if (clr) begin
                check("in_ready_during_clr", 32'(in_ready), 32'd0);
                check("ram_re_during_clr", 32'(ram_re), 32'd0);
                exp_q.delete();
                exp_wa      = 5'd0;
                exp_ra      = 5'd0;
                ram_pending = 0;
            end else begin
                if (ram_re) begin
                    check("issue_has_data", 32'(ram_pending > 0), 32'd1);
                    check("ram_ra", 32'(ram_ra), 32'(exp_ra));
                    exp_ra = addr_inc(exp_ra);
                    ram_pending--;
                end
                if (in_valid && in_ready) begin
                    check("ram_we", 32'(ram_we), 32'd1);
                    check("ram_wa", 32'(ram_wa), 32'(exp_wa));
                    check("ram_di", ram_di, in_data);
                    exp_q.push_back(in_data);
                    exp_wa = addr_inc(exp_wa);
                    ram_pending++;
                end else begin
                    check("ram_we_idle", 32'(ram_we), 32'd0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("pop_from_empty_model", 32'd1, 32'd0);
                    end else begin
                        check("out_data", out_data, exp_q.pop_front());
                    end
                    pop_cnt++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Present one word and hold it until accepted or the budget runs out.
    task automatic push_word(input logic [31:0] d, input int budget, output bit acc);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        acc      = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
            if (k < budget - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic rand_traffic(input int n, input int ready_pct);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 99) < 60);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    endtask

    task automatic drain(input int budget);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit          acc;
        bit          got;
        int          p0;
        int          stalls;
        logic        re_h  [6];
        logic        ore_h [6];
        logic        ov_h  [6];
        logic [31:0] od_h  [6];
        logic [5:0]  fc_h  [6];

        rst           = 1'b0;
        clr           = 1'b0;
        in_valid      = 1'b0;
        in_data       = 32'd0;
        out_ready     = 1'b0;
        pwrbus_ram_pd = $urandom;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_re", 32'(ram_re), 32'd0);
        check("rst_ram_ore", 32'(ram_ore), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        check("pwrbus_pass", ram_pwrbus_ram_pd, pwrbus_ram_pd);
        check("byp_sel_tie", 32'(ram_byp_sel), 32'd0);
        check("dbyp_tie", ram_dbyp, 32'd0);

        // Single-word latency
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_0001;
        out_ready = 1'b1;
        @(negedge clk);
        check("single_push_accept", 32'(in_ready), 32'd1);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            re_h[c]  = ram_re;
            ore_h[c] = ram_ore;
            ov_h[c]  = out_valid;
            od_h[c]  = out_data;
            fc_h[c]  = fifo_count;
        end
        check("lat_re_c1", 32'(re_h[1]), 32'd1);
        check("lat_ore_c1", 32'(ore_h[1]), 32'd0);
        check("lat_ore_c2", 32'(ore_h[2]), 32'd1);
        check("lat_ov_c3", 32'(ov_h[3]), 32'd0);
        check("lat_ov_c4", 32'(ov_h[4]), 32'd1);
        check("lat_data_c4", od_h[4], 32'hA5A5_0001);
        check("lat_count_c5", 32'(fc_h[5]), 32'd0);

        // Fill to capacity with the consumer stalled
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 24; i++) begin
            push_word(32'(i), 5, acc);
            if (i < 23) check("fill_accept", 32'(acc), 32'd1);
            else        check("fill_reject_24th", 32'(acc), 32'd0);
        end
        idle(1);
        @(negedge clk);
        check("full_count", 32'(fifo_count), 32'd23);
        check("full_in_ready", 32'(in_ready), 32'd0);
        p0 = pop_cnt;
        drain(80);
        check("full_pop_total", 32'(pop_cnt - p0), 32'd23);

        // Streaming: one push and one pop per cycle
        p0     = pop_cnt;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'b1;
            in_data   = $urandom;
            out_ready = 1'b1;
            @(negedge clk);
            if (!in_ready) stalls++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("stream_stalls", 32'(stalls), 32'd0);
        check("stream_pops_by_c103", 32'(pop_cnt - p0), 32'd100);
        drain(20);

        // Random traffic with 30% consumer throttling
        rand_traffic(400, 70);
        drain(200);

        // Flush with reads in flight
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            push_word(32'hC000_0000 + 32'(i), 5, acc);
            check("clr_fill_accept", 32'(acc), 32'd1);
        end
        idle(3);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(posedge clk);
        #1 clr = 1'b1;
        @(negedge clk);
        check("clr_ore_in_flight", 32'(ram_ore), 32'd1);
        check("clr_count_before", 32'(fifo_count), 32'd10);
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("clr_count_after", 32'(fifo_count), 32'd0);
        check("clr_out_valid_after", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        push_word(32'h0000_1234, 5, acc);
        check("post_clr_accept", 32'(acc), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("post_clr_out_valid", 32'(got), 32'd1);
        check("post_clr_first_word", out_data, 32'h0000_1234);
        drain(20);

        // Asynchronous reset mid-stream
        rand_traffic(60, 70);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_fifo_count", 32'(fifo_count), 32'd0);
        check("midrst_ram_we", 32'(ram_we), 32'd0);
        check("midrst_ram_re", 32'(ram_re), 32'd0);
        check("midrst_ram_ore", 32'(ram_ore), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("after_midrst_in_ready", 32'(in_ready), 32'd1);
        rand_traffic(200, 70);
        drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
